// File: rtl/debug_unit.sv
// Debug command controller: decodes host bytes, loads instruction memory,
// gates the CPU clock enable for run/step and sends the PC back over the UART.
module debug_unit #(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               CLK100MHZ,
  input  logic               SWITCH_RESET,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  input  logic               halt,
  input  logic [LEN-1:0]     pc,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               imem_wr_en,
  output logic [NB_ADDR-1:0] imem_addr,
  output logic [LEN-1:0]     imem_data,
  output logic               cpu_enable,
  output logic               cpu_reset,
  output logic [2:0]         state_dbg
);

  localparam int NBYTES = LEN / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);

  localparam logic [7:0] CMD_START   = 8'h01;
  localparam logic [7:0] CMD_CONT    = 8'h02;
  localparam logic [7:0] CMD_STEPMOD = 8'h03;
  localparam logic [7:0] CMD_REPROG  = 8'h05;
  localparam logic [7:0] CMD_STEP    = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_PROGRAM   = 3'd2,
    S_RUN       = 3'd3,
    S_WAIT_STEP = 3'd4,
    S_STEP      = 3'd5,
    S_SEND      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [LEN-1:0]       wdata_q, wdata_d;
  logic                 halted_q, halted_d;
  logic                 step_q, step_d;
  logic [BC_W-1:0]      tx_idx_q, tx_idx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  // Bytes received so far for the word being assembled; the last byte joins on the fly.
  logic [LEN-9:0]       word_q, word_d;
  logic [LEN-1:0]       pc_cap_q, pc_cap_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    halted_d   = halted_q;
    step_d     = step_q;
    tx_idx_d   = tx_idx_q;
    tx_busy_d  = tx_busy_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    word_d     = word_q;
    pc_cap_d   = pc_cap_q;
    cpu_enable = 1'b0;
    cpu_reset  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (rx_done && rx_data == CMD_START) state_d = S_READY;
      end
      S_READY: begin
        cpu_reset = 1'b1;
        if (rx_done) begin
          case (rx_data)
            CMD_REPROG: begin
              state_d    = S_PROGRAM;
              addr_d     = '0;
              byte_cnt_d = '0;
            end
            CMD_CONT:    state_d = S_RUN;
            CMD_STEPMOD: begin
              state_d = S_WAIT_STEP;
              step_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_PROGRAM: begin
        cpu_reset = 1'b1;
        if (rx_done) begin
          word_d = {rx_data, word_q[LEN-9:8]};
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            wr_en_d    = 1'b1;
            wdata_d    = {rx_data, word_q};
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        // End marker or last address stops the load without wrapping the address.
        if (wr_en_q) begin
          if (wdata_q == '1 || addr_q == '1) state_d = S_READY;
          else                               addr_d  = addr_q + 1'b1;
        end
      end
      S_RUN: begin
        cpu_enable = 1'b1;
        if (halt) begin
          pc_cap_d = pc;
          halted_d = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_WAIT_STEP: begin
        if (rx_done && rx_data == CMD_STEP) state_d = S_STEP;
      end
      S_STEP: begin
        cpu_enable = 1'b1;
        if (halt) halted_d = 1'b1;
        pc_cap_d = pc;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = pc_cap_q[{tx_idx_q, 3'b000} +: 8];
          tx_busy_d  = 1'b1;
        end else if (tx_done) begin
          tx_busy_d = 1'b0;
          if (tx_idx_q == LAST_BYTE) begin
            tx_idx_d = '0;
            state_d  = (step_q && !halted_q) ? S_WAIT_STEP : S_DONE;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (rx_done && rx_data == CMD_START) begin
          state_d  = S_READY;
          halted_d = 1'b0;
          step_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (SWITCH_RESET) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      halted_q   <= 1'b0;
      step_q     <= 1'b0;
      tx_idx_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      halted_q   <= halted_d;
      step_q     <= step_d;
      tx_idx_q   <= tx_idx_d;
      tx_busy_q  <= tx_busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    word_q   <= word_d;
    pc_cap_q <= pc_cap_d;
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign imem_wr_en = wr_en_q;
  assign imem_addr  = addr_q;
  assign imem_data  = wdata_q;
  assign state_dbg  = state_q;

endmodule
